// File: rtl/cam_lookup_arbiter.sv
// Round-robin arbiter sharing one CAM/LUT lookup engine between NUM_REQ requesters.
// It tracks the requester ID of each in-flight lookup, routes each result back to the
// requester that issued it, and holds off lookups so a pending LUT write can complete.
module cam_lookup_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned CMP_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH = 3,
  parameter int unsigned TAG_DEPTH  = 8,
  parameter int unsigned MAX_BURST  = 16,
  parameter int unsigned ID_BITS    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*CMP_WIDTH-1:0]   req_cmp_data,
  input  logic [NUM_REQ*CMP_WIDTH-1:0]   req_cmp_dmask,
  output logic [NUM_REQ-1:0]             gnt,
  output logic [NUM_REQ-1:0]             resp_valid,
  output logic                           resp_hit,
  output logic [DATA_WIDTH-1:0]          resp_data,
  output logic                           lookup_req,
  output logic [CMP_WIDTH-1:0]           lookup_cmp_data,
  output logic [CMP_WIDTH-1:0]           lookup_cmp_dmask,
  input  logic                           lookup_ack,
  input  logic                           lookup_hit,
  input  logic [DATA_WIDTH-1:0]          lookup_data,
  input  logic                           wr_req_mon,
  input  logic                           wr_ack_mon,
  output logic                           tag_err
);

  localparam int unsigned TAG_BITS   = $clog2(TAG_DEPTH);
  localparam int unsigned BURST_BITS = $clog2(MAX_BURST) + 1;

  typedef enum logic [0:0] {ARB, WR_HOLD} state_t;

  state_t                state_q, state_d;
  logic [ID_BITS-1:0]    rr_ptr;
  logic [ID_BITS-1:0]    winner_c;
  logic [ID_BITS-1:0]    scan_idx_c;
  logic                  found_c;
  logic                  issue_c;
  logic                  pop_c;
  logic                  full_c;
  logic [NUM_REQ-1:0]    elig_c;
  logic [ID_BITS-1:0]    fifo_mem [TAG_DEPTH];
  logic [TAG_BITS-1:0]   wr_idx, rd_idx;
  logic [TAG_BITS:0]     count;
  logic [BURST_BITS-1:0] burst_cnt;

  // The requester granted last cycle is masked so it can drop or re-assert its request.
  assign elig_c  = req & ~gnt;
  assign full_c  = (count == (TAG_BITS + 1)'(TAG_DEPTH));
  assign pop_c   = lookup_ack && (count != '0);
  assign issue_c = (state_q == ARB) && !full_c && found_c;

  // Pick the first eligible requester after the round-robin pointer, wrapping.
  always_comb begin
    winner_c   = '0;
    found_c    = 1'b0;
    scan_idx_c = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      scan_idx_c = ID_BITS'((32'(rr_ptr) + i) % NUM_REQ);
      if (!found_c && elig_c[scan_idx_c]) begin
        winner_c = scan_idx_c;
        found_c  = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ARB;
    else       state_q <= state_d;
  end

  // Enter write hold on the issue that completes a full burst; leave once the write is done or withdrawn.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB:     if (issue_c && wr_req_mon && (burst_cnt == BURST_BITS'(MAX_BURST - 1))) state_d = WR_HOLD;
      WR_HOLD: if (wr_ack_mon || !wr_req_mon) state_d = ARB;
      default: state_d = ARB;
    endcase
  end

  // Grant/issue, response routing, ID FIFO pointers, burst counter and the sticky error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      gnt              <= '0;
      lookup_req       <= 1'b0;
      lookup_cmp_data  <= '0;
      lookup_cmp_dmask <= '0;
      resp_valid       <= '0;
      resp_hit         <= 1'b0;
      resp_data        <= '0;
      tag_err          <= 1'b0;
      rr_ptr           <= ID_BITS'(NUM_REQ - 1);
      wr_idx           <= '0;
      rd_idx           <= '0;
      count            <= '0;
      burst_cnt        <= '0;
    end else begin
      gnt        <= '0;
      lookup_req <= 1'b0;
      resp_valid <= '0;
      if (issue_c) begin
        gnt              <= NUM_REQ'(1) << winner_c;
        lookup_req       <= 1'b1;
        lookup_cmp_data  <= req_cmp_data[32'(winner_c) * CMP_WIDTH +: CMP_WIDTH];
        lookup_cmp_dmask <= req_cmp_dmask[32'(winner_c) * CMP_WIDTH +: CMP_WIDTH];
        rr_ptr           <= winner_c;
        wr_idx           <= wr_idx + TAG_BITS'(1);
      end
      if (pop_c) begin
        resp_valid <= NUM_REQ'(1) << fifo_mem[rd_idx];
        resp_hit   <= lookup_hit;
        resp_data  <= lookup_data;
        rd_idx     <= rd_idx + TAG_BITS'(1);
      end else if (lookup_ack) begin
        tag_err <= 1'b1;
      end
      if (issue_c && !pop_c)      count <= count + (TAG_BITS + 1)'(1);
      else if (!issue_c && pop_c) count <= count - (TAG_BITS + 1)'(1);
      if (issue_c && wr_req_mon) burst_cnt <= burst_cnt + BURST_BITS'(1);
      else                       burst_cnt <= '0;
    end
  end

  // ID storage for in-flight lookups; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (issue_c) fifo_mem[wr_idx] <= winner_c;
  end

endmodule

// File: tb/tb_cam_lookup_arbiter.sv
// Self-checking bench for cam_lookup_arbiter: directed scenarios plus randomized traffic,
// every cycle compared against a queue-based behavioural model.
module tb_cam_lookup_arbiter;

  localparam int N  = 4;
  localparam int CW = 32;
  localparam int DW = 3;
  localparam int TD = 8;
  localparam int MB = 16;

  logic            clk;
  logic            reset;
  logic [N-1:0]    req;
  logic [N*CW-1:0] req_cmp_data;
  logic [N*CW-1:0] req_cmp_dmask;
  logic [N-1:0]    gnt;
  logic [N-1:0]    resp_valid;
  logic            resp_hit;
  logic [DW-1:0]   resp_data;
  logic            lookup_req;
  logic [CW-1:0]   lookup_cmp_data;
  logic [CW-1:0]   lookup_cmp_dmask;
  logic            lookup_ack;
  logic            lookup_hit;
  logic [DW-1:0]   lookup_data;
  logic            wr_req_mon;
  logic            wr_ack_mon;
  logic            tag_err;

  cam_lookup_arbiter dut (
    .clk(clk), .reset(reset), .req(req),
    .req_cmp_data(req_cmp_data), .req_cmp_dmask(req_cmp_dmask),
    .gnt(gnt), .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_data(resp_data),
    .lookup_req(lookup_req), .lookup_cmp_data(lookup_cmp_data), .lookup_cmp_dmask(lookup_cmp_dmask),
    .lookup_ack(lookup_ack), .lookup_hit(lookup_hit), .lookup_data(lookup_data),
    .wr_req_mon(wr_req_mon), .wr_ack_mon(wr_ack_mon), .tag_err(tag_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Behavioural model: outputs expected after the next clock edge.
  logic [N-1:0]  exp_gnt = '0;
  logic [N-1:0]  exp_rv = '0;
  logic          exp_hit = 1'b0;
  logic [DW-1:0] exp_data = '0;
  logic          exp_lreq = 1'b0;
  logic [CW-1:0] exp_cd = '0;
  logic [CW-1:0] exp_cm = '0;
  logic          exp_terr = 1'b0;
  int            m_ptr = N - 1;
  int            q[$];
  bit            m_hold = 1'b0;
  int            m_burst = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    logic [N-1:0] elig;
    int  win;
    bit  issue;
    int  old_size;
    if (reset) begin
      exp_gnt = '0; exp_rv = '0; exp_hit = 1'b0; exp_data = '0; exp_lreq = 1'b0;
      exp_cd = '0; exp_cm = '0; exp_terr = 1'b0;
      m_ptr = N - 1; q.delete(); m_hold = 1'b0; m_burst = 0;
      return;
    end
    elig = req & ~exp_gnt;
    win = -1;
    for (int i = 1; i <= N; i++) begin
      int k;
      k = (m_ptr + i) % N;
      if (win < 0 && elig[k]) win = k;
    end
    old_size = q.size();
    issue = !m_hold && (old_size < TD) && (win >= 0);
    exp_rv = '0;
    if (lookup_ack) begin
      if (old_size > 0) begin
        exp_rv[q[0]] = 1'b1;
        exp_hit = lookup_hit;
        exp_data = lookup_data;
        void'(q.pop_front());
      end else begin
        exp_terr = 1'b1;
      end
    end
    exp_gnt = '0;
    exp_lreq = 1'b0;
    if (issue) begin
      exp_gnt[win] = 1'b1;
      exp_lreq = 1'b1;
      exp_cd = req_cmp_data[win*CW +: CW];
      exp_cm = req_cmp_dmask[win*CW +: CW];
      q.push_back(win);
      m_ptr = win;
    end
    if (m_hold) begin
      m_burst = 0;
      if (wr_ack_mon || !wr_req_mon) m_hold = 1'b0;
    end else if (issue && wr_req_mon) begin
      m_burst++;
      if (m_burst == MB) m_hold = 1'b1;
    end else begin
      m_burst = 0;
    end
  endtask

  task automatic compare_all();
    check("gnt", 64'(gnt), 64'(exp_gnt));
    check("resp_valid", 64'(resp_valid), 64'(exp_rv));
    check("resp_hit", 64'(resp_hit), 64'(exp_hit));
    check("resp_data", 64'(resp_data), 64'(exp_data));
    check("lookup_req", 64'(lookup_req), 64'(exp_lreq));
    check("lookup_cmp_data", 64'(lookup_cmp_data), 64'(exp_cd));
    check("lookup_cmp_dmask", 64'(lookup_cmp_dmask), 64'(exp_cm));
    check("tag_err", 64'(tag_err), 64'(exp_terr));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0; lookup_ack = 1'b0; wr_req_mon = 1'b0; wr_ack_mon = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int n_issue;
    logic [N-1:0] exp_seq [6];
    logic [CW-1:0] key;
    reset = 1'b1; req = '0; lookup_ack = 1'b0; lookup_hit = 1'b0; lookup_data = '0;
    wr_req_mon = 1'b0; wr_ack_mon = 1'b0;
    for (int k = 0; k < N; k++) begin
      req_cmp_data[k*CW +: CW] = CW'($urandom);
      req_cmp_dmask[k*CW +: CW] = CW'($urandom);
    end
    tick();
    do_reset();
    check("reset_gnt", 64'(gnt), 64'd0);
    check("reset_cmp", 64'(lookup_cmp_data), 64'd0);

    // Single lookup with a hit
    key = 32'h0A000001;
    req_cmp_data[0 +: CW] = key;
    req = 4'b0001;
    tick();
    check("t1_gnt", 64'(gnt), 64'd1);
    check("t1_lreq", 64'(lookup_req), 64'd1);
    check("t1_key", 64'(lookup_cmp_data), 64'h0A000001);
    req = '0; lookup_ack = 1'b1; lookup_hit = 1'b1; lookup_data = 3'd3;
    tick();
    lookup_ack = 1'b0;
    check("t1_rv", 64'(resp_valid), 64'd1);
    check("t1_hit", 64'(resp_hit), 64'd1);
    check("t1_data", 64'(resp_data), 64'd3);

    // Round robin across all requesters, then in-order responses
    do_reset();
    exp_seq = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2};
    req = 4'hF;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("t2_gnt", 64'(gnt), 64'(exp_seq[i]));
    end
    req = '0; lookup_ack = 1'b1;
    for (int i = 0; i < 6; i++) begin
      lookup_data = DW'(i);
      tick();
      check("t2_rv", 64'(resp_valid), 64'(exp_seq[i]));
    end
    lookup_ack = 1'b0;

    // FIFO depth limit
    do_reset();
    req = 4'hF;
    n_issue = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      n_issue += int'(lookup_req);
    end
    check("t3_full_issues", 64'(n_issue), 64'd8);
    lookup_ack = 1'b1;
    n_issue = 0;
    tick();
    n_issue += int'(lookup_req);
    lookup_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_issue += int'(lookup_req);
    end
    check("t3_after_ack", 64'(n_issue), 64'd1);

    // Write fairness burst limit
    do_reset();
    req = 4'hF; wr_req_mon = 1'b1;
    n_issue = 0;
    for (int i = 0; i < 25; i++) begin
      lookup_ack = (q.size() > 0);
      tick();
      n_issue += int'(lookup_req);
    end
    check("t4_burst", 64'(n_issue), 64'd16);
    lookup_ack = 1'b0; wr_ack_mon = 1'b1;
    tick();
    check("t4_hold_lreq", 64'(lookup_req), 64'd0);
    wr_ack_mon = 1'b0; wr_req_mon = 1'b0;
    tick();
    check("t4_resume", 64'(lookup_req), 64'd1);

    // Ack with nothing outstanding
    do_reset();
    lookup_ack = 1'b1;
    tick();
    lookup_ack = 1'b0;
    check("t5_terr", 64'(tag_err), 64'd1);
    check("t5_rv", 64'(resp_valid), 64'd0);
    tick(); tick();
    check("t5_sticky", 64'(tag_err), 64'd1);

    // Reset with lookups in flight
    do_reset();
    req = 4'hF;
    for (int i = 0; i < 5; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; req = '0;
    check("t6_lreq", 64'(lookup_req), 64'd0);
    check("t6_gnt", 64'(gnt), 64'd0);
    check("t6_cmp", 64'(lookup_cmp_data), 64'd0);
    lookup_ack = 1'b1;
    tick();
    lookup_ack = 1'b0;
    check("t6_terr", 64'(tag_err), 64'd1);
    check("t6_rv", 64'(resp_valid), 64'd0);

    // Randomized traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 799) == 0);
      req = N'($urandom);
      for (int k = 0; k < N; k++) begin
        req_cmp_data[k*CW +: CW] = CW'($urandom);
        req_cmp_dmask[k*CW +: CW] = CW'($urandom);
      end
      if (q.size() > 0) lookup_ack = ($urandom_range(0, 2) != 0);
      else              lookup_ack = ($urandom_range(0, 63) == 0);
      lookup_hit = 1'($urandom);
      lookup_data = DW'($urandom);
      if ($urandom_range(0, 39) == 0) wr_req_mon = ~wr_req_mon;
      wr_ack_mon = ($urandom_range(0, 15) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
